// File: rtl/demux1x4_tdm_pkg.sv
// Shared definitions for the TDM receive demux: FSM state encoding and
// the slot-index width derivation.
package demux1x4_tdm_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int DEF_WIDTH    = 1;
  localparam int DEF_CHANNELS = 4;

  // Slot index width; never below 1 so sel stays a real register.
  function automatic int sel_w_f(input int channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/demux1x4_tdm.sv
// Receive end of the 4:1 TDM path: steers each valid sample into its slot
// register and releases the whole frame as one registered parallel word.
module demux1x4_tdm
  import demux1x4_tdm_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = sel_w_f(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      valid_in,
  input  logic                      sof,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic                      frame_valid,
  output logic [SEL_W-1:0]          sel,
  output logic                      frame_err
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);

  state_t                            state;
  logic [CHANNELS-1:0][WIDTH-1:0]    staging;

  // The last slot bypasses staging so the frame reaches data_out one edge
  // after its final sample; a sof in COLLECT restarts the frame at slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      sel         <= '0;
      staging     <= '0;
      data_out    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (valid_in) begin
        if (sof) begin
          staging[0] <= data_in;
          sel        <= SEL_ONE;
          state      <= COLLECT;
          if ((state == COLLECT) && (sel != '0)) begin
            frame_err <= 1'b1;
          end
        end else if (state == COLLECT) begin
          staging[sel] <= data_in;
          if (sel == LAST_SLOT) begin
            data_out    <= {data_in, staging[CHANNELS-2:0]};
            frame_valid <= 1'b1;
            sel         <= '0;
          end else begin
            sel <= sel + SEL_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_demux1x4_tdm.sv
// Scoreboard bench for demux1x4_tdm: stimulus pushes expected frame/error
// events, an independent monitor pops and compares on every output pulse.
module tb_demux1x4_tdm;

  logic       clk;
  logic       rst;
  logic [0:0] data_in;
  logic       valid_in;
  logic       sof;
  logic [3:0] data_out;
  logic       frame_valid;
  logic [1:0] sel;
  logic       frame_err;

  typedef struct {
    logic       err;
    logic [3:0] data;
    logic [1:0] sel;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  demux1x4_tdm #(.WIDTH(1), .CHANNELS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .sof        (sof),
    .data_out   (data_out),
    .frame_valid(frame_valid),
    .sel        (sel),
    .frame_err  (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of stimulus; inputs change 1ns after the rising edge.
  task automatic applyStimulus(input logic v, input logic s, input logic d);
    valid_in = v;
    sof      = s;
    data_in  = d;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sof      = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic expectFrame(input logic [3:0] d);
    exp_t e;
    e.err = 1'b0; e.data = d; e.sel = 2'd0;
    exp_q.push_back(e);
  endtask

  task automatic expectErr(input logic [3:0] held);
    exp_t e;
    e.err = 1'b1; e.data = held; e.sel = 2'd1;
    exp_q.push_back(e);
  endtask

  // Sends slots 0..3 of bits; optional idle gap between slots 1 and 2.
  task automatic sendFrame(input logic [3:0] bits, input logic first_sof,
                           input int gap, input logic check_sel);
    for (int j = 0; j < 4; j++) begin
      if (j == 3) expectFrame(bits);
      applyStimulus(1'b1, (j == 0) ? first_sof : 1'b0, bits[j]);
      if (check_sel) checkOutput($sformatf("sel_after_slot%0d", j), 32'(sel), 32'((j + 1) % 4));
      if (j == 1) begin
        for (int g = 0; g < gap; g++) begin
          applyStimulus(1'b0, (g == 1), 1'b1);
          checkOutput("sel_hold_gap", 32'(sel), 32'd2);
        end
      end
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_valid === 1'b1 || frame_err === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("[TB] FAIL unexpected_pulse: frame_valid=%b frame_err=%b data_out=%h at %0t",
                   frame_valid, frame_err, data_out, $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pulse_frame_valid", 32'(frame_valid), 32'(!e.err));
          checkOutput("pulse_frame_err", 32'(frame_err), 32'(e.err));
          checkOutput("pulse_data_out", 32'(data_out), 32'(e.data));
          checkOutput("pulse_sel", 32'(sel), 32'(e.sel));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; sof = 1'b0; data_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_data_out", 32'(data_out), 32'd0);
    checkOutput("reset_sel", 32'(sel), 32'd0);
    checkOutput("reset_frame_valid", 32'(frame_valid), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);

    // HUNT discards non-sof samples
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("hunt_sel", 32'(sel), 32'd0);
      checkOutput("hunt_frame_valid", 32'(frame_valid), 32'd0);
    end
    checkOutput("hunt_data_out", 32'(data_out), 32'd0);

    // Aligned frame: slots 1,0,1,1 -> 4'b1101
    sendFrame(4'b1101, 1'b1, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("aligned_hold", 32'(data_out), 32'hD);

    // 16 back-to-back frames, sof only on the first
    for (int i = 0; i < 16; i++) begin
      sendFrame(4'(i), (i == 0), 0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("b2b_last", 32'(data_out), 32'hF);

    // Gap of 3 idle cycles (one with stray sof) between slots 1 and 2
    sendFrame(4'b1101, 1'b1, 3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Mid-frame sof: error, output held, restart with 1 then 0,0,1
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    expectErr(4'b1101);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("midsof_sel", 32'(sel), 32'd1);
    checkOutput("midsof_data_out", 32'(data_out), 32'hD);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectFrame(4'b1001);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset mid-frame with a valid sof sample on the reset cycle
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("pre_rst_sel", 32'(sel), 32'd2);
    rst = 1'b1; valid_in = 1'b1; sof = 1'b1; data_in = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; valid_in = 1'b0; sof = 1'b0; data_in = 1'b0;
    checkOutput("rst_mid_data_out", 32'(data_out), 32'd0);
    checkOutput("rst_mid_sel", 32'(sel), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("post_rst_hunt_sel", 32'(sel), 32'd0);
    sendFrame(4'b0110, 1'b1, 0, 1'b1);

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
